// File: rtl/aes_sbox_pkg.sv
// Shared AES S-box constants and lookup helper for the sub-word pipeline.
package aes_sbox_pkg;

  localparam int unsigned LaneW       = 8;
  localparam int unsigned DefaultLanes = 4;
  localparam int unsigned DefaultCntW  = 16;

  localparam logic [7:0] SboxFwd [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SboxInv [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [LaneW-1:0] sbox_lookup(input logic [LaneW-1:0] b, input logic inv);
    return inv ? SboxInv[b] : SboxFwd[b];
  endfunction

endpackage

// File: rtl/sbox_byte.sv
// Combinational single-byte AES substitution; inverse table only reachable when INV_EN is set.
module sbox_byte
  import aes_sbox_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [LaneW-1:0] i_byte,
  input  logic             i_inv,
  output logic [LaneW-1:0] o_byte
);

  always_comb begin
    o_byte = sbox_lookup(i_byte, INV_EN && i_inv);
  end

endmodule

// File: rtl/sub_word_pipe.sv
// Two-stage valid/ready pipeline applying AES SubBytes or InvSubBytes to every byte lane.
module sub_word_pipe
  import aes_sbox_pkg::*;
#(
  parameter int unsigned LANES  = DefaultLanes,
  parameter bit          INV_EN = 1'b1,
  parameter int unsigned CNT_W  = DefaultCntW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [LaneW*LANES-1:0] i_in_data,
  input  logic                   i_in_inv,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [LaneW*LANES-1:0] o_out_data,
  output logic                   o_out_inv,
  output logic [CNT_W-1:0]       o_word_cnt
);

  localparam int unsigned W = LaneW * LANES;

  logic             r_s1_valid, r_s1_inv;
  logic [W-1:0]     r_s1_data;
  logic             r_s2_valid, r_s2_inv;
  logic [W-1:0]     r_s2_data;
  logic [CNT_W-1:0] r_cnt;

  logic         w_s2_load;
  logic         w_s1_adv;
  logic         w_s1_load;
  logic         w_in_fire;
  logic         w_out_fire;
  logic [W-1:0] w_sub;

  always_comb begin
    w_s2_load  = !r_s2_valid || i_out_ready;
    w_s1_adv   = r_s1_valid && w_s2_load;
    w_s1_load  = !r_s1_valid || w_s1_adv;
    w_in_fire  = i_in_valid && w_s1_load;
    w_out_fire = r_s2_valid && i_out_ready;
    // Held low during reset so nothing is accepted before the first edge after release.
    o_in_ready = rst_n && w_s1_load;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sbox_byte #(
      .INV_EN(INV_EN)
    ) u_sbox (
      .i_byte(r_s1_data[g*LaneW +: LaneW]),
      .i_inv (r_s1_inv),
      .o_byte(w_sub[g*LaneW +: LaneW])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_inv   <= 1'b0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_inv   <= 1'b0;
      r_s2_data  <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= i_in_valid;
      end
      if (w_in_fire) begin
        r_s1_data <= i_in_data;
        r_s1_inv  <= INV_EN && i_in_inv;
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s1_adv) begin
        r_s2_data <= w_sub;
        r_s2_inv  <= r_s1_inv;
      end
      if (w_out_fire) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_out_valid = r_s2_valid;
  assign o_out_data  = r_s2_data;
  assign o_out_inv   = r_s2_inv;
  assign o_word_cnt  = r_cnt;

endmodule

// File: tb/tb_sub_word_pipe.sv
// Scoreboard bench: S-boxes derived from GF(2^8) inversion plus affine map, two DUT configurations.
module tb_sub_word_pipe;

  localparam int unsigned L = 4;
  localparam int unsigned W = 8 * L;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid, in_inv, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, out_inv;
  logic [W-1:0] out_data;
  logic [15:0]  word_cnt;
  logic         in_ready_b, out_valid_b, out_inv_b;
  logic [W-1:0] out_data_b;
  logic [3:0]   word_cnt_b;

  always #5 clk = ~clk;

  sub_word_pipe #(.LANES(L), .INV_EN(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_inv(in_inv), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_inv(out_inv), .o_word_cnt(word_cnt)
  );

  // Forward-only, 4-bit counter instance fed by the same stimulus.
  sub_word_pipe #(.LANES(L), .INV_EN(1'b0), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready_b),
    .i_in_data(in_data), .i_in_inv(in_inv), .o_out_valid(out_valid_b), .i_out_ready(out_ready),
    .o_out_data(out_data_b), .o_out_inv(out_inv_b), .o_word_cnt(word_cnt_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int delivered = 0;

  logic [7:0] m_fwd [256];
  logic [7:0] m_inv [256];

  typedef struct packed {
    logic [W-1:0] d;
    logic         inv;
    logic [W-1:0] d_b;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  logic         stall_q = 1'b0;
  logic [W-1:0] stall_data;
  logic         stall_inv;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  task automatic build_model();
    logic [7:0] av, bv, iv, s;
    for (int a = 0; a < 256; a++) begin
      av = a[7:0];
      iv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        bv = b[7:0];
        if (av != 8'h00 && gmul(av, bv) == 8'h01) iv = bv;
      end
      s = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
      m_fwd[a] = s;
      m_inv[s] = av;
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] r;
    for (int i = 0; i < L; i++) r[8*i +: 8] = inv ? m_inv[d[8*i +: 8]] : m_fwd[d[8*i +: 8]];
    return r;
  endfunction

  // Monitor and scoreboard: all DUT sampling on the falling edge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      delivered = 0;
      stall_q = 1'b0;
    end else begin
      check("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2) || out_ready});
      check("in_ready_b", {63'd0, in_ready_b}, {63'd0, (q.size() < 2) || out_ready});
      check("word_cnt", {48'd0, word_cnt}, 64'(delivered % 65536));
      check("word_cnt_b", {60'd0, word_cnt_b}, 64'(delivered % 16));
      if (stall_q) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_hold", {31'd0, out_inv, out_data}, {31'd0, stall_inv, stall_data});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", {63'd0, out_valid}, 64'd0);
        end else begin
          mon_e = q.pop_front();
          check("out_data", {32'd0, out_data}, {32'd0, mon_e.d});
          check("out_inv", {63'd0, out_inv}, {63'd0, mon_e.inv});
          check("out_valid_b", {63'd0, out_valid_b}, 64'd1);
          check("out_data_b", {32'd0, out_data_b}, {32'd0, mon_e.d_b});
          check("out_inv_b", {63'd0, out_inv_b}, 64'd0);
        end
        delivered++;
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
      stall_inv  = out_inv;
      if (in_valid && in_ready) begin
        q.push_back('{d: model(in_data, in_inv), inv: in_inv, d_b: model(in_data, 1'b0)});
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic inv);
    int guard;
    guard = 0;
    in_valid = 1'b1; in_data = d; in_inv = inv;
    @(negedge clk);
    while (!in_ready && guard < 1000) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 500) begin
      guard++;
      @(posedge clk);
    end
    check("drain", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int t0;
    logic [7:0] vb;
    logic done;
    in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0;
    build_model();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_word_cnt", {48'd0, word_cnt}, 64'd0);
    check("rst_out_data", {31'd0, out_inv, out_data}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed forward lookup with exact latency.
    out_ready = 1'b1;
    send(32'h0001_53FF, 1'b0);
    @(negedge clk);
    check("lat_not_early", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("lat_valid", {63'd0, out_valid}, 64'd1);
    check("fwd_const", {32'd0, out_data}, 64'h637C_ED16);
    check("fwd_inv", {63'd0, out_inv}, 64'd0);
    @(posedge clk); #1;
    check("fwd_cnt", {48'd0, word_cnt}, 64'd1);

    // Directed inverse; forward-only instance gives the forward result.
    send(32'h637C_ED16, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("inv_const", {32'd0, out_data}, 64'h0001_53FF);
    check("inv_mode", {63'd0, out_inv}, 64'd1);
    check("inv_b_const", {32'd0, out_data_b}, 64'hFB10_5547);
    check("inv_b_mode", {63'd0, out_inv_b}, 64'd0);
    @(posedge clk); #1;

    // 15 more words: 17 transfers wraps the 4-bit counter to 1.
    for (int i = 0; i < 15; i++) send($urandom, 1'($urandom_range(0, 1)));
    drain();
    check("wrap_cnt_b", {60'd0, word_cnt_b}, 64'd1);
    check("cnt_17", {48'd0, word_cnt}, 64'd17);

    // Exhaustive sweep, back-to-back.
    t0 = cyc;
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        vb = v[7:0];
        send({vb + 8'd3, vb ^ 8'ha5, ~vb, vb}, m[0]);
      end
    end
    check("sweep_cycles", 64'(cyc - t0), 64'd512);
    drain();
    check("sweep_cnt", {48'd0, word_cnt}, 64'd529);

    // Backpressure: 4 words while output stalls for 5 cycles.
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 4; i++) send($urandom, 1'(i));
      begin
        repeat (5) @(posedge clk);
        #1;
        check("bp_held", 64'(q.size()), 64'd2);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random backpressure and gaps.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          send($urandom, 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(32'hDEAD_BEEF, 1'b0);
    send(32'h1234_5678, 1'b1);
    @(posedge clk); #1;
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_cnt", {48'd0, word_cnt}, 64'd0);
    check("midrst_data", {31'd0, out_inv, out_data}, 64'd0);
    check("midrst_valid_b", {63'd0, out_valid_b}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1; in_data = 32'hA5C3_0F1E; in_inv = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_q", 64'(q.size()), 64'd0);
    check("post_rst_cnt", {48'd0, word_cnt}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    check("global_timeout", 64'(cyc), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sub_word_pipe.md
SUB_WORD_PIPE -- requirements
Module: sub_word_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning the number of byte lanes substituted per transfer (legal 1..16).
REQ-002 SHALL have parameter INV_EN, default 1, meaning the inverse S-box path is present; 0 means forward only.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of the accepted-word counter.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-006 IN_VALID  input  1  upstream word is valid.
REQ-007 IN_READY  output  1  block accepts a word this cycle.
REQ-008 IN_DATA  input  8*LANES  input word; lane i = bits [8i+7:8i].
REQ-009 IN_INV  input  1  per-word mode: 0 = forward SubBytes, 1 = InvSubBytes.
REQ-010 OUT_VALID  output  1  OUT_DATA and OUT_INV are valid.
REQ-011 OUT_READY  input  1  downstream accepts the output this cycle.
REQ-012 OUT_DATA  output  8*LANES  substituted word, lane-aligned with IN_DATA.
REQ-013 OUT_INV  output  1  mode that was used for OUT_DATA.
REQ-014 WORD_CNT  output  CNT_W  count of words delivered at the output (OUT_VALID and OUT_READY both high).

Function
REQ-015 Each output lane SHALL equal the AES forward S-box (FIPS-197) of the input lane when the word's mode is 0, and the AES inverse S-box when the mode is 1.
REQ-016 When INV_EN=0, IN_INV SHALL be ignored, the forward S-box SHALL always be used, and OUT_INV SHALL be 0.
REQ-017 SHALL be a two-stage pipeline:
  - S1 registers IN_DATA and the mode.
  - S2 registers the lookup result.
  - Latency from acceptance to OUT_VALID is 2 cycles with no stall.
REQ-018 A transfer SHALL occur only when VALID and READY are both high in the same cycle, on both ports.
REQ-019 Stage advance rules:
  - S2 SHALL load when it is empty or being drained.
  - S1 SHALL load when it is empty or advancing into S2.
  - IN_READY = !s1_valid | s1_advance. IN_READY may depend combinationally on OUT_READY.
REQ-020 Full throughput: with OUT_READY held high, one word per cycle SHALL be sustained.
REQ-021 Stall behaviour:
  - With OUT_READY low and both stages full, IN_READY SHALL be 0.
  - OUT_DATA and OUT_INV SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-022 A stalled pipeline holds at most 2 words; no word SHALL be dropped or duplicated.
REQ-023 Mode SHALL travel with its word; mixed forward/inverse words in flight SHALL each use their own mode.
REQ-024 WORD_CNT SHALL increment by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.
REQ-025 Simultaneous input accept and output drain in the same cycle SHALL both take effect, with no bubble inserted.

Reset
REQ-026 While RST_N=0, the following SHALL hold immediately, regardless of the clock:
  - OUT_VALID=0, WORD_CNT=0, internal valids=0.
  - OUT_DATA=0, OUT_INV=0.
  - IN_READY=1 is permitted only after RST_N deasserts.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight words, with no output transfer for them after release.
REQ-028 The first word after release SHALL be accepted no earlier than the first rising edge with RST_N=1.

Structure
REQ-029 Package aes_sbox_pkg SHALL hold:
  - the 256-entry forward and inverse S-box constant tables;
  - the LANES and CNT_W defaults;
  - the lane-width constant (8).
REQ-030 Sub-module sbox_byte SHALL be combinational (byte in, mode in, byte out), be instantiated LANES times via generate, and contain no state.
REQ-031 All sequential logic (valids, data and mode registers, counter) SHALL reside in sub_word_pipe.

Verification
REQ-032 Forward lookup, LANES=4: IN_DATA=0x0001_53FF, IN_INV=0, OUT_READY=1 -> OUT_DATA=0x637C_ED16, OUT_INV=0, 2 cycles after acceptance, WORD_CNT=1.
REQ-033 Inverse lookup: IN_DATA=0x637C_ED16, IN_INV=1 -> OUT_DATA=0x0001_53FF, OUT_INV=1; with INV_EN=0 the same stimulus -> forward result 0xFB10_5547, OUT_INV=0.
REQ-034 Exhaustive sweep: all 256 byte values in every lane, both modes, back-to-back, OUT_READY=1 -> every result matches the package tables; one word per cycle; WORD_CNT=512 (mod 2^CNT_W).
REQ-035 Backpressure: OUT_READY=0 for 5 cycles while streaming 4 words -> IN_READY drops after 2 accepts, OUT_DATA is stable, all 4 words emerge in order after release.
REQ-036 Reset mid-stream: assert RST_N=0 with 2 words in flight -> OUT_VALID=0 and WORD_CNT=0 at once; no stale word appears after release.
REQ-037 Counter wrap: CNT_W=4, 17 transfers -> WORD_CNT=1.
